// File: rtl/i2s_rx_10xe.sv
// I2S receiver: synchronises an external I2S bus onto m_axis_aud_aclk and streams samples over AXI-stream.
// Optional macro I2S_RX_LJ_MODE_EN adds cfg_lj for left-justified reception.
module i2s_rx_10xe #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        m_axis_aud_aclk,
    input  logic        m_axis_aud_aresetn,
    input  logic        sclk_in,
    input  logic        lrclk_in,
    input  logic        sdata_in,
    input  logic        cfg_en,
    input  logic        cfg_w24,
`ifdef I2S_RX_LJ_MODE_EN
    input  logic        cfg_lj,
`endif
    output logic [31:0] m_axis_aud_tdata,
    output logic        m_axis_aud_tid,
    output logic        m_axis_aud_tvalid,
    input  logic        m_axis_aud_tready,
    output logic        ovf_o,
    output logic        ferr_o,
    input  logic        err_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, WAIT} state_t;

    logic        sclk_s1_q, sclk_s2_q, sclk_dly_q;
    logic        lr_s1_q, lr_s2_q, sd_s1_q, sd_s2_q;
    logic        lr_prev_q, lr_vld_q;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ch_q, ch_d;
    logic        w24_q, w24_d;
    logic [23:0] sh_q, sh_d;
    logic        push_q, push_d;
    logic        ferr_set;
    logic        ferr_q, ovf_q;
    logic        lj;
    logic        sclk_rise, lr_chg;
    logic [31:0] push_word;

    logic [32:0]  mem_q [FIFO_DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         fifo_full, fifo_empty, pop, wr_en, ovf_set;

`ifdef I2S_RX_LJ_MODE_EN
    assign lj = cfg_lj;
`else
    assign lj = 1'b0;
`endif

    assign sclk_rise = sclk_s2_q & ~sclk_dly_q;
    // The first edge after reset only seeds lr_prev_q, so capture waits for a real word boundary.
    assign lr_chg    = sclk_rise & lr_vld_q & (lr_s2_q != lr_prev_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        w24_d    = w24_q;
        sh_d     = sh_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        if (!cfg_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = ALIGN;
                default: begin
                    if (lr_chg) begin
                        ferr_set = (state_q == SHIFT);
                        state_d  = SHIFT;
                        ch_d     = lj ? ~lr_s2_q : lr_s2_q;
                        w24_d    = cfg_w24;
                        if (lj) begin
                            // Left-justified: the MSB arrives on the boundary edge itself.
                            sh_d  = {sh_q[22:0], sd_s2_q};
                            cnt_d = cfg_w24 ? 5'd23 : 5'd15;
                        end else begin
                            cnt_d = cfg_w24 ? 5'd24 : 5'd16;
                        end
                    end else if (sclk_rise && state_q == SHIFT) begin
                        sh_d  = {sh_q[22:0], sd_s2_q};
                        cnt_d = cnt_q - 5'd1;
                        if (cnt_q == 5'd1) begin
                            state_d = WAIT;
                            push_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge m_axis_aud_aclk) begin
        if (!m_axis_aud_aresetn) begin
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_dly_q <= 1'b0;
            lr_s1_q    <= 1'b0;
            lr_s2_q    <= 1'b0;
            sd_s1_q    <= 1'b0;
            sd_s2_q    <= 1'b0;
            lr_prev_q  <= 1'b0;
            lr_vld_q   <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            ch_q       <= 1'b0;
            w24_q      <= 1'b0;
            sh_q       <= '0;
            push_q     <= 1'b0;
        end else begin
            sclk_s1_q  <= sclk_in;
            sclk_s2_q  <= sclk_s1_q;
            sclk_dly_q <= sclk_s2_q;
            lr_s1_q    <= lrclk_in;
            lr_s2_q    <= lr_s1_q;
            sd_s1_q    <= sdata_in;
            sd_s2_q    <= sd_s1_q;
            if (sclk_rise) begin
                lr_prev_q <= lr_s2_q;
                lr_vld_q  <= 1'b1;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            w24_q   <= w24_d;
            sh_q    <= sh_d;
            push_q  <= push_d;
        end
    end

    assign push_word = w24_q ? {{8{sh_q[23]}}, sh_q} : {{16{sh_q[15]}}, sh_q[15:0]};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = m_axis_aud_tvalid & m_axis_aud_tready;
    assign wr_en      = push_q & cfg_en & (~fifo_full | pop);
    assign ovf_set    = push_q & cfg_en & fifo_full & ~pop;

    always_ff @(posedge m_axis_aud_aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {ch_q, push_word};
        end
    end

    always_ff @(posedge m_axis_aud_aclk) begin
        if (!m_axis_aud_aresetn || !cfg_en) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sticky flags; a clear request wins over a same-cycle set.
    always_ff @(posedge m_axis_aud_aclk) begin
        if (!m_axis_aud_aresetn) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (err_clr)       ferr_q <= 1'b0;
            else if (ferr_set) ferr_q <= 1'b1;
            if (err_clr)       ovf_q  <= 1'b0;
            else if (ovf_set)  ovf_q  <= 1'b1;
        end
    end

    assign m_axis_aud_tvalid = ~fifo_empty;
    assign {m_axis_aud_tid, m_axis_aud_tdata} = fifo_empty ? 33'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign ovf_o  = ovf_q;
    assign ferr_o = ferr_q;

endmodule

// File: tb/tb_i2s_rx_10xe.sv
// Scoreboard bench for i2s_rx_10xe: directed I2S frames, expected beats queued at stimulus time.
module tb_i2s_rx_10xe;

    logic        clk;
    logic        rstn;
    logic        sclk, lrclk, sdata;
    logic        cfg_en, cfg_w24;
`ifdef I2S_RX_LJ_MODE_EN
    logic        cfg_lj;
`endif
    logic [31:0] tdata;
    logic        tid, tvalid, tready;
    logic        ovf, ferr, err_clr;

    logic [32:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    i2s_rx_10xe #(.FIFO_DEPTH(4)) dut (
        .m_axis_aud_aclk   (clk),
        .m_axis_aud_aresetn(rstn),
        .sclk_in           (sclk),
        .lrclk_in          (lrclk),
        .sdata_in          (sdata),
        .cfg_en            (cfg_en),
        .cfg_w24           (cfg_w24),
`ifdef I2S_RX_LJ_MODE_EN
        .cfg_lj            (cfg_lj),
`endif
        .m_axis_aud_tdata  (tdata),
        .m_axis_aud_tid    (tid),
        .m_axis_aud_tvalid (tvalid),
        .m_axis_aud_tready (tready),
        .ovf_o             (ovf),
        .ferr_o            (ferr),
        .err_clr           (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Monitor: compare every accepted beat against the head of the scoreboard.
    always begin
        logic [32:0] exp;
        @(negedge clk);
        #1;
        if (rstn && tvalid && tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got tid=%0d data=%h, required no beat", tid, tdata);
            end else begin
                exp = sb.pop_front();
                if ({tid, tdata} !== exp) begin
                    errors++;
                    $display("FAIL beat: got tid=%0d data=%h, required tid=%0d data=%h",
                             tid, tdata, exp[32], exp[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic sbit(input logic lr, input logic d);
        sclk = 1'b0; lrclk = lr; sdata = d;
        #40;
        sclk = 1'b1;
        #40;
    endtask

    // I2S slot: bit 0 is the delay bit, bits 1..w carry the sample MSB first.
    task automatic send_word(input logic lr, input logic [23:0] v, input int w, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (i >= 1 && i <= w) b = v[w-i];
            sbit(lr, b);
        end
    endtask

    task automatic send_lj(input logic lr, input logic [23:0] v, input int w, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'b0;
            if (i < w) b = v[w-1-i];
            sbit(lr, b);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; sclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
        cfg_en = 1'b0; cfg_w24 = 1'b1; tready = 1'b1; err_clr = 1'b0;
`ifdef I2S_RX_LJ_MODE_EN
        cfg_lj = 1'b0;
`endif
        repeat (5) @(negedge clk);
        chk("reset_tvalid", {31'd0, tvalid}, 32'd0);
        chk("reset_tdata", tdata, 32'd0);
        chk("reset_tid", {31'd0, tid}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        chk("reset_ferr", {31'd0, ferr}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        cfg_en = 1'b1;
        repeat (3) @(negedge clk);

        // 24-bit stereo frame
        sbit(1'b1, 1'b0); sbit(1'b1, 1'b0);
        sb.push_back({1'b0, 32'h0012_3456});
        send_word(1'b0, 24'h123456, 24, 32);
        sb.push_back({1'b1, 32'hFFAB_CDEF});
        send_word(1'b1, 24'hABCDEF, 24, 32);
        drain();

        // 16-bit samples in 32-bit half-frames
        cfg_w24 = 1'b0;
        sb.push_back({1'b0, 32'hFFFF_8001});
        send_word(1'b0, 24'h008001, 16, 32);
        sb.push_back({1'b1, 32'h0000_7FFF});
        send_word(1'b1, 24'h007FFF, 16, 32);
        drain();
        chk("ferr_after_16bit", {31'd0, ferr}, 32'd0);

        // short frame: lrclk toggles after 10 bits
        cfg_w24 = 1'b1;
        send_word(1'b0, 24'hFFFFFF, 24, 11);
        sb.push_back({1'b1, 32'hFF80_0000});
        send_word(1'b1, 24'h800000, 24, 32);
        drain();
        chk("ferr_short_frame", {31'd0, ferr}, 32'd1);
        pulse_clr();
        chk("ferr_cleared", {31'd0, ferr}, 32'd0);

        // overflow: five words into a four-deep FIFO with sink stalled
        tready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sb.push_back({logic'((k - 1) % 2), 32'(k)});
            send_word(logic'((k - 1) % 2), 24'(k), 24, 32);
        end
        repeat (10) @(negedge clk);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("stall_tvalid", {31'd0, tvalid}, 32'd1);
        chk("stall_tdata", tdata, 32'd1);
        pulse_clr();
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        tready = 1'b1;
        drain();

        // disable with two words queued and one in progress
        tready = 1'b0;
        send_word(1'b1, 24'h111111, 24, 32);
        send_word(1'b0, 24'h222222, 24, 32);
        send_word(1'b1, 24'h333333, 24, 9);
        @(negedge clk);
        chk("queued_tvalid", {31'd0, tvalid}, 32'd1);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("flush_tvalid", {31'd0, tvalid}, 32'd0);
        cfg_en = 1'b1;
        tready = 1'b1;
        for (int k = 0; k < 10; k++) sbit(1'b1, 1'b1);
        sb.push_back({1'b0, 32'h0034_5678});
        send_word(1'b0, 24'h345678, 24, 32);
        sb.push_back({1'b1, 32'h000A_BCDE});
        send_word(1'b1, 24'h0ABCDE, 24, 32);
        drain();

`ifdef I2S_RX_LJ_MODE_EN
        // left-justified: lrclk high is left, MSB on the boundary edge
        cfg_lj = 1'b1;
        sb.push_back({1'b1, 32'h0000_0000});
        send_lj(1'b0, 24'h000000, 24, 32);
        sb.push_back({1'b0, 32'h0000_000F});
        send_lj(1'b1, 24'h00000F, 24, 32);
        drain();
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("final_ferr", {31'd0, ferr}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_10xe.md
I2S_RX_10XE -- requirements
Module: i2s_rx_10xe

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output word FIFO depth; power of two, 2..16.
REQ-002 m_axis_aud_aclk  input  1  sole clock; all logic rising-edge.
REQ-003 m_axis_aud_aresetn  input  1  reset, synchronous, active-low.
REQ-004 sclk_in  input  1  external I2S bit clock, asynchronous, at most aclk/4.
REQ-005 lrclk_in  input  1  external word-select; 0 = left, 1 = right.
REQ-006 sdata_in  input  1  external serial data, MSB first.
REQ-007 cfg_en  input  1  receiver enable.
REQ-008 cfg_w24  input  1  sample width; 1 = 24 bits, 0 = 16 bits.
REQ-009 m_axis_aud_tdata  output  32  received sample, sign-extended to 32 bits.
REQ-010 m_axis_aud_tid  output  1  channel; 0 = left, 1 = right.
REQ-011 m_axis_aud_tvalid  output  1  AXI-stream valid.
REQ-012 m_axis_aud_tready  input  1  AXI-stream ready.
REQ-013 ovf_o  output  1  sticky FIFO overflow flag.
REQ-014 ferr_o  output  1  sticky short-frame flag.
REQ-015 err_clr  input  1  single-cycle pulse; clears ovf_o and ferr_o.

Function
REQ-016 sclk_in, lrclk_in and sdata_in shall each pass through a 2-flop synchronizer.
REQ-017 An sclk rising edge is detected when synchronized sclk = 1 and its registered copy = 0.
- On each detected edge, sdata and lrclk are sampled together.
REQ-018 FSM states shall be IDLE, ALIGN, SHIFT and WAIT.
- IDLE while cfg_en = 0.
- IDLE -> ALIGN when cfg_en = 1.
REQ-019 An lrclk change is a sampled lrclk that differs from the previous sampled lrclk.
- From ALIGN, SHIFT or WAIT, an lrclk change loads channel = new lrclk and bit counter = width, then enters SHIFT.
- The data bit sampled on that same edge is not captured (I2S one-bit delay).
REQ-020 In SHIFT, each sclk edge shifts one bit into the shift register and decrements the counter.
- When the counter reaches 0, go to WAIT and assert a push the following aclk cycle.
REQ-021 In WAIT, extra bits shall be ignored until the next lrclk change.
REQ-022 An lrclk change while in SHIFT (fewer than width bits received) shall discard the partial word, set ferr_o, and restart SHIFT for the new channel.
REQ-023 The pushed word shall be sign-extended from bit 23 or bit 15 to 32 bits, with tid = channel.
REQ-024 Latency from the sclk edge that samples the LSB, as seen in aclk, to tvalid = 1 shall be at most 4 aclk cycles (synchronizer + detect + push + FIFO register).
REQ-025 AXI-stream handshake:
- tdata and tid shall hold stable while tvalid = 1 and tready = 0.
- A pop occurs only when tvalid and tready are both 1.
REQ-026 A push to a full FIFO shall drop the new word and set ovf_o.
- A simultaneous push and pop when full shall succeed with no overflow.
REQ-027 FIFO pointers shall wrap modulo FIFO_DEPTH.
REQ-028 cfg_en 1->0 shall, in the next cycle:
- return the FSM to IDLE;
- discard any partial word;
- flush the FIFO (tvalid = 0).
REQ-029 err_clr takes priority over a set event occurring in the same cycle.
REQ-030 A change to cfg_w24 takes effect only at the next lrclk change.

Reset
REQ-031 While m_axis_aud_aresetn = 0 at a clock edge, the following shall clear:
- tvalid = 0, tdata = 0, tid = 0;
- ovf_o = 0, ferr_o = 0;
- FSM = IDLE, FIFO empty;
- synchronizers and shift register = 0.
REQ-032 Reset asserted mid-word shall lose all partial and queued data.
- After release, capture resumes only after an lrclk change.

Configuration
REQ-033 Macro I2S_RX_LJ_MODE_EN adds input port cfg_lj (1 bit).
- cfg_lj = 1 selects left-justified mode: MSB is sampled on the same edge as the lrclk change, and lrclk = 1 means left.
- cfg_lj = 0 keeps I2S timing.
REQ-034 Without I2S_RX_LJ_MODE_EN, the port is absent and behaviour is I2S-only, identical to cfg_lj = 0.

Verification
REQ-035 24-bit I2S, left = 0x123456, right = 0xABCDEF, tready = 1 -> two beats:
- 0x00123456 with tid = 0;
- 0xFFABCDEF with tid = 1.
REQ-036 16-bit, left = 0x8001 in a 32-sclk half-frame -> tdata = 0xFFFF8001; the trailing 16 bits are ignored; ferr_o = 0.
REQ-037 tready = 0, FIFO_DEPTH = 4, 5 words received -> ovf_o = 1, FIFO holds the first 4 words; err_clr pulse -> ovf_o = 0.
REQ-038 lrclk toggles after 10 bits of a 24-bit word -> ferr_o = 1, no beat output; the next full word is received correctly.
REQ-039 cfg_en dropped with 2 words queued and a word in progress -> tvalid = 0 next cycle; after re-enable, the first word out is from a fresh frame.
REQ-040 With I2S_RX_LJ_MODE_EN and cfg_lj = 1, left-justified left = 0x00000F (24-bit) -> tdata = 0x0000000F, tid = 0.
